core_reg_router: RTL and testbench

CORE_REG_ROUTER -- requirements
Module: core_reg_router

---
 rtl/core_reg_router_pkg.sv | 25 ++
 rtl/core_reg_router.sv | 144 ++++++++++++++
 tb/tb_core_reg_router.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_reg_router_pkg.sv
// Shared widths, constants and payload types for the core register router.
package core_reg_router_pkg;

  localparam int unsigned CPCI_NF2_DATA_WIDTH = 32;
  localparam int unsigned CORE_REG_ADDR_WIDTH = 24;
  localparam int unsigned WORD_ADDR_WIDTH     = CORE_REG_ADDR_WIDTH - 2;
  localparam int unsigned SLOT_WIDTH          = 4;
  localparam int unsigned BLOCK_ADDR_WIDTH    = WORD_ADDR_WIDTH - SLOT_WIDTH;
  localparam int unsigned MAX_SLOTS           = 16;
  localparam int unsigned CNT_WIDTH           = 10;

  localparam logic [CPCI_NF2_DATA_WIDTH-1:0] DEAD_BEEF = 32'hDEAD_BEEF;

  // Latched request broadcast to every slot
  typedef struct packed {
    logic                              rd_wr_L;
    logic [BLOCK_ADDR_WIDTH-1:0]       addr;
    logic [CPCI_NF2_DATA_WIDTH-1:0]    wr_data;
  } reg_cmd_t;

  function automatic logic [SLOT_WIDTH-1:0] addr_slot(input logic [WORD_ADDR_WIDTH-1:0] addr);
    return addr[WORD_ADDR_WIDTH-1 -: SLOT_WIDTH];
  endfunction

endpackage

// File: rtl/core_reg_router.sv
// Routes upstream core register accesses to one of NUM_SLAVES block slots by the
// top address nibble, with per-access timeout and DEAD_BEEF for empty slots.
module core_reg_router
  import core_reg_router_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      core_reg_req,
  output logic                                      core_reg_ack,
  input  logic                                      core_reg_rd_wr_L,
  input  logic [WORD_ADDR_WIDTH-1:0]                core_reg_addr,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0]            core_reg_wr_data,
  output logic [CPCI_NF2_DATA_WIDTH-1:0]            core_reg_rd_data,
  output logic [NUM_SLAVES-1:0]                     slv_reg_req,
  output logic                                      slv_reg_rd_wr_L,
  output logic [BLOCK_ADDR_WIDTH-1:0]               slv_reg_addr,
  output logic [CPCI_NF2_DATA_WIDTH-1:0]            slv_reg_wr_data,
  input  logic [NUM_SLAVES-1:0]                     slv_reg_ack,
  input  logic [NUM_SLAVES*CPCI_NF2_DATA_WIDTH-1:0] slv_reg_rd_data,
  output logic                                      timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t                         state_q, state_n;
  reg_cmd_t                       cmd_q, cmd_n;
  logic [SLOT_WIDTH-1:0]          slot_q, slot_n;
  logic [CNT_WIDTH-1:0]           cnt_q, cnt_n;
  logic [NUM_SLAVES-1:0]          req_q, req_n;
  logic                           ack_q, ack_n;
  logic [CPCI_NF2_DATA_WIDTH-1:0] rd_data_q, rd_data_n;
  logic                           tmo_q, tmo_n;

  logic                           sel_ack;
  logic [CPCI_NF2_DATA_WIDTH-1:0] sel_data;

  // Ack and read data of the currently selected slot only
  always_comb begin
    sel_ack  = 1'b0;
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (slot_q == SLOT_WIDTH'(k)) begin
        sel_ack  = slv_reg_ack[k];
        sel_data = slv_reg_rd_data[k*CPCI_NF2_DATA_WIDTH +: CPCI_NF2_DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cmd_q     <= '{rd_wr_L: 1'b1, addr: '0, wr_data: '0};
      slot_q    <= '0;
      cnt_q     <= '0;
      req_q     <= '0;
      ack_q     <= 1'b0;
      rd_data_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      cmd_q     <= cmd_n;
      slot_q    <= slot_n;
      cnt_q     <= cnt_n;
      req_q     <= req_n;
      ack_q     <= ack_n;
      rd_data_q <= rd_data_n;
      tmo_q     <= tmo_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    cmd_n     = cmd_q;
    slot_n    = slot_q;
    cnt_n     = cnt_q;
    req_n     = req_q;
    ack_n     = 1'b0;
    rd_data_n = rd_data_q;
    tmo_n     = 1'b0;

    case (state_q)
      IDLE: begin
        if (core_reg_req) begin
          cmd_n.rd_wr_L = core_reg_rd_wr_L;
          cmd_n.addr    = core_reg_addr[BLOCK_ADDR_WIDTH-1:0];
          cmd_n.wr_data = core_reg_wr_data;
          slot_n        = addr_slot(core_reg_addr);
          if (32'(slot_n) < NUM_SLAVES) begin
            req_n   = NUM_SLAVES'(1) << slot_n;
            cnt_n   = '0;
            state_n = WAIT_ACK;
          end else begin
            ack_n     = 1'b1;
            rd_data_n = DEAD_BEEF;
            state_n   = DONE;
          end
        end
      end

      WAIT_ACK: begin
        if (!core_reg_req) begin
          req_n   = '0;
          state_n = IDLE;
        end else if (sel_ack) begin
          // A slave ack on the expiry cycle still wins over the timeout
          req_n     = '0;
          ack_n     = 1'b1;
          rd_data_n = sel_data;
          state_n   = DONE;
        end else if (cnt_q == CNT_WIDTH'(TIMEOUT - 1)) begin
          req_n     = '0;
          ack_n     = 1'b1;
          rd_data_n = DEAD_BEEF;
          tmo_n     = 1'b1;
          state_n   = DONE;
        end else begin
          cnt_n = cnt_q + CNT_WIDTH'(1);
        end
      end

      DONE: begin
        if (!core_reg_req) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  assign core_reg_ack     = ack_q;
  assign core_reg_rd_data = rd_data_q;
  assign slv_reg_req      = req_q;
  assign slv_reg_rd_wr_L  = cmd_q.rd_wr_L;
  assign slv_reg_addr     = cmd_q.addr;
  assign slv_reg_wr_data  = cmd_q.wr_data;
  assign timeout_err      = tmo_q;

endmodule

// File: tb/tb_core_reg_router.sv
// Directed bench for core_reg_router with NUM_SLAVES=4, TIMEOUT=8.
module tb_core_reg_router;
  import core_reg_router_pkg::*;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = CPCI_NF2_DATA_WIDTH;

  logic                          clk;
  logic                          reset;
  logic                          core_reg_req;
  logic                          core_reg_ack;
  logic                          core_reg_rd_wr_L;
  logic [WORD_ADDR_WIDTH-1:0]    core_reg_addr;
  logic [DW-1:0]                 core_reg_wr_data;
  logic [DW-1:0]                 core_reg_rd_data;
  logic [NS-1:0]                 slv_reg_req;
  logic                          slv_reg_rd_wr_L;
  logic [BLOCK_ADDR_WIDTH-1:0]   slv_reg_addr;
  logic [DW-1:0]                 slv_reg_wr_data;
  logic [NS-1:0]                 slv_reg_ack;
  logic [NS*DW-1:0]              slv_reg_rd_data;
  logic                          timeout_err;
  logic [DW-1:0]                 sd [NS];

  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt;

  assign slv_reg_rd_data = {sd[3], sd[2], sd[1], sd[0]};

  core_reg_router #(.NUM_SLAVES(NS), .TIMEOUT(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .core_reg_req     (core_reg_req),
    .core_reg_ack     (core_reg_ack),
    .core_reg_rd_wr_L (core_reg_rd_wr_L),
    .core_reg_addr    (core_reg_addr),
    .core_reg_wr_data (core_reg_wr_data),
    .core_reg_rd_data (core_reg_rd_data),
    .slv_reg_req      (slv_reg_req),
    .slv_reg_rd_wr_L  (slv_reg_rd_wr_L),
    .slv_reg_addr     (slv_reg_addr),
    .slv_reg_wr_data  (slv_reg_wr_data),
    .slv_reg_ack      (slv_reg_ack),
    .slv_reg_rd_data  (slv_reg_rd_data),
    .timeout_err      (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},     32'(core_reg_ack),    32'h0);
    check({tag, "_rd_data"}, core_reg_rd_data,     32'h0);
    check({tag, "_slv_req"}, 32'(slv_reg_req),     32'h0);
    check({tag, "_rd_wr_L"}, 32'(slv_reg_rd_wr_L), 32'h1);
    check({tag, "_addr"},    32'(slv_reg_addr),    32'h0);
    check({tag, "_wr_data"}, slv_reg_wr_data,      32'h0);
    check({tag, "_tmo"},     32'(timeout_err),     32'h0);
  endtask

  task automatic issue(input logic [3:0] slot, input logic [17:0] off, input logic rw, input logic [DW-1:0] wd);
    core_reg_addr    = {slot, off};
    core_reg_rd_wr_L = rw;
    core_reg_wr_data = wd;
    core_reg_req     = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    core_reg_req = 1'b0;
    core_reg_rd_wr_L = 1'b1;
    core_reg_addr = '0;
    core_reg_wr_data = '0;
    slv_reg_ack = '0;
    for (int i = 0; i < int'(NS); i++) sd[i] = '0;
    step(); step();
    check_reset_outputs("rst");
    reset = 1'b0;
    step();

    // Read slot 0 offset 3, slave acks one cycle after seeing req
    issue(4'd0, 18'd3, 1'b1, 32'h0);
    step();
    check("rd0_slv_req", 32'(slv_reg_req), 32'h1);
    check("rd0_slv_addr", 32'(slv_reg_addr), 32'h3);
    check("rd0_rd_wr_L", 32'(slv_reg_rd_wr_L), 32'h1);
    check("rd0_ack_c1", 32'(core_reg_ack), 32'h0);
    step();
    check("rd0_ack_c2", 32'(core_reg_ack), 32'h0);
    slv_reg_ack = 4'b0001;
    sd[0] = 32'h0000_0001;
    step();
    slv_reg_ack = '0;
    check("rd0_ack_c3", 32'(core_reg_ack), 32'h1);
    check("rd0_rd_data", core_reg_rd_data, 32'h0000_0001);
    check("rd0_req_drop", 32'(slv_reg_req), 32'h0);
    core_reg_req = 1'b0;
    step();
    check("rd0_ack_pulse", 32'(core_reg_ack), 32'h0);

    // Unpopulated slot 9
    issue(4'd9, 18'h0, 1'b1, 32'h0);
    step();
    check("s9_ack", 32'(core_reg_ack), 32'h1);
    check("s9_rd_data", core_reg_rd_data, 32'hDEAD_BEEF);
    check("s9_slv_req", 32'(slv_reg_req), 32'h0);
    check("s9_tmo", 32'(timeout_err), 32'h0);
    core_reg_req = 1'b0;
    step();
    check("s9_ack_pulse", 32'(core_reg_ack), 32'h0);

    // Slot 2 never acks: req high for 8 cycles, then timeout
    issue(4'd2, 18'h10, 1'b1, 32'h0);
    step();
    check("to_req_c1", 32'(slv_reg_req), 32'h4);
    for (int i = 0; i < 7; i++) begin
      step();
      check("to_req_hold", 32'(slv_reg_req), 32'h4);
      check("to_no_ack", 32'(core_reg_ack), 32'h0);
    end
    step();
    check("to_req_drop", 32'(slv_reg_req), 32'h0);
    check("to_ack", 32'(core_reg_ack), 32'h1);
    check("to_rd_data", core_reg_rd_data, 32'hDEAD_BEEF);
    check("to_tmo", 32'(timeout_err), 32'h1);
    step();
    check("to_tmo_pulse", 32'(timeout_err), 32'h0);
    check("to_ack_pulse", 32'(core_reg_ack), 32'h0);
    core_reg_req = 1'b0;
    step();

    // Ack arriving on the expiry cycle wins over the timeout
    issue(4'd2, 18'h0, 1'b1, 32'h0);
    sd[2] = 32'h2222_0002;
    for (int i = 0; i < 8; i++) step();
    slv_reg_ack = 4'b0100;
    step();
    slv_reg_ack = '0;
    check("race_ack", 32'(core_reg_ack), 32'h1);
    check("race_rd_data", core_reg_rd_data, 32'h2222_0002);
    check("race_tmo", 32'(timeout_err), 32'h0);
    core_reg_req = 1'b0;
    step();

    // Write slot 1 while slot 3 acks spuriously
    issue(4'd1, 18'h2A, 1'b0, 32'hA5A5_5A5A);
    sd[3] = 32'h3333_3333;
    sd[1] = 32'h1111_1111;
    step();
    check("wr_slv_req", 32'(slv_reg_req), 32'h2);
    check("wr_wr_data", slv_reg_wr_data, 32'hA5A5_5A5A);
    check("wr_rd_wr_L", 32'(slv_reg_rd_wr_L), 32'h0);
    slv_reg_ack = 4'b1000;
    step();
    check("wr_spur_ack", 32'(core_reg_ack), 32'h0);
    check("wr_spur_req", 32'(slv_reg_req), 32'h2);
    slv_reg_ack = 4'b0010;
    step();
    slv_reg_ack = '0;
    check("wr_ack", 32'(core_reg_ack), 32'h1);
    check("wr_rd_data", core_reg_rd_data, 32'h1111_1111);

    // Request held 20 cycles after ack: no re-ack, no new slave req
    ack_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (core_reg_ack) ack_cnt++;
      if (slv_reg_req != '0) ack_cnt += 100;
    end
    check("held_reack", 32'(ack_cnt), 32'h0);
    core_reg_req = 1'b0;
    step();
    issue(4'd0, 18'h5, 1'b1, 32'h0);
    step();
    check("held_next_req", 32'(slv_reg_req), 32'h1);

    // Upstream drops req in WAIT_ACK: abort
    core_reg_req = 1'b0;
    step();
    check("abort_req", 32'(slv_reg_req), 32'h0);
    check("abort_ack", 32'(core_reg_ack), 32'h0);
    step();
    check("abort_ack2", 32'(core_reg_ack), 32'h0);

    // Reset during WAIT_ACK, then a fresh request completes
    issue(4'd1, 18'h7, 1'b0, 32'hCAFE_F00D);
    step();
    check("mr_req", 32'(slv_reg_req), 32'h2);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("mr");
    step();
    check("mr_no_ack", 32'(core_reg_ack), 32'h0);
    reset = 1'b0;
    step();
    check("mr_new_req", 32'(slv_reg_req), 32'h2);
    check("mr_new_wr", slv_reg_wr_data, 32'hCAFE_F00D);
    slv_reg_ack = 4'b0010;
    sd[1] = 32'h0BAD_F00D;
    step();
    slv_reg_ack = '0;
    check("mr_ack", 32'(core_reg_ack), 32'h1);
    check("mr_rd_data", core_reg_rd_data, 32'h0BAD_F00D);
    core_reg_req = 1'b0;
    step();
    check("mr_ack_pulse", 32'(core_reg_ack), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
